// File: rtl/rs_sym_fifo.sv
// Symbol FIFO for the RS decoder datapath: occupancy count, threshold flags, overflow/underflow pulses.
// FWFT=0 gives a registered read (1 cycle); FWFT=1 falls through via an output register after 2 cycles.
module rs_sym_fifo #(
  parameter int SYM_BW    = 8,
  parameter int DEPTH     = 1024,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [SYM_BW-1:0] datain,
  input  logic              rd,
  output logic [SYM_BW-1:0] dataout,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     level,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [AW-1:0] LAST_C   = AW'(DEPTH - 1);

  logic [SYM_BW-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     level_q, level_d;
  logic [SYM_BW-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ovf_q, unf_q;
  logic              empty_w, full_w, rd_ok, wr_ok, pop_mem;
  logic [CW-1:0]     mem_cnt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign full_w  = (level_q == DEPTH_C);
  assign empty_w = (FWFT != 0) ? !valid_q : (level_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    pop_mem  = 1'b0;
    // In FWFT mode the output register holds one entry, so the array holds level minus valid.
    mem_cnt  = level_q - {{(CW-1){1'b0}}, valid_q};
    rd_ok    = rd & !empty_w;
    wr_ok    = wr & (!full_w | rd_ok);

    if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);

    unique case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (FWFT != 0) begin
      // Refill the output register from the array whenever it is free or being popped.
      if ((!valid_q || rd_ok) && (mem_cnt != '0)) begin
        pop_mem = 1'b1;
        dout_d  = mem_q[rd_ptr_q];
        valid_d = 1'b1;
      end else if (rd_ok) begin
        valid_d = 1'b0;
      end
    end else if (rd_ok) begin
      pop_mem = 1'b1;
      dout_d  = mem_q[rd_ptr_q];
    end

    if (pop_mem) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ovf_q    <= wr & !wr_ok;
      unf_q    <= rd & !rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_ptr_q] <= datain;
  end

  assign dataout      = dout_q;
  assign empty        = empty_w;
  assign full         = full_w;
  assign almost_full  = (level_q >= AFULL_C);
  assign almost_empty = (level_q <= AEMPTY_C);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_rs_sym_fifo.sv
// Directed bench for rs_sym_fifo: DEPTH=16 standard, DEPTH=5 wrap traffic, DEPTH=8 FWFT.
module tb_rs_sym_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // DUT A: DEPTH=16, FWFT=0
  logic       a_wr = 0, a_rd = 0;
  logic [7:0] a_din = 0, a_dout;
  logic       a_empty, a_full, a_af, a_ae, a_ovf, a_unf;
  logic [4:0] a_level;
  // DUT B: DEPTH=5, FWFT=0
  logic       b_wr = 0, b_rd = 0;
  logic [7:0] b_din = 0, b_dout;
  logic       b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_level;
  // DUT C: DEPTH=8, FWFT=1
  logic       c_wr = 0, c_rd = 0;
  logic [7:0] c_din = 0, c_dout;
  logic       c_empty, c_full, c_af, c_ae, c_ovf, c_unf;
  logic [3:0] c_level;

  rs_sym_fifo #(.SYM_BW(8), .DEPTH(16), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .wr(a_wr), .datain(a_din), .rd(a_rd), .dataout(a_dout),
    .empty(a_empty), .full(a_full), .almost_full(a_af), .almost_empty(a_ae),
    .level(a_level), .overflow(a_ovf), .underflow(a_unf));

  rs_sym_fifo #(.SYM_BW(8), .DEPTH(5), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .wr(b_wr), .datain(b_din), .rd(b_rd), .dataout(b_dout),
    .empty(b_empty), .full(b_full), .almost_full(b_af), .almost_empty(b_ae),
    .level(b_level), .overflow(b_ovf), .underflow(b_unf));

  rs_sym_fifo #(.SYM_BW(8), .DEPTH(8), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .wr(c_wr), .datain(c_din), .rd(c_rd), .dataout(c_dout),
    .empty(c_empty), .full(c_full), .almost_full(c_af), .almost_empty(c_ae),
    .level(c_level), .overflow(c_ovf), .underflow(c_unf));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [16:0] got, exp;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    // {dout, level, empty, full, af, ae, ovf, unf}; AFULL_TH=12 so af=0
    got = {a_dout, a_level, a_empty, a_full, a_af, a_ae, a_ovf, a_unf};
    exp = {8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== exp) $display("FAIL reset_a got=%h exp=%h", got, exp); else passed++;
    checks++;
    if ({c_empty, c_level, c_dout} !== {1'b1, 4'd0, 8'h00})
      $display("FAIL reset_c empty=%b level=%0d dout=%h", c_empty, c_level, c_dout);
    else passed++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      a_wr = 1'b1;
      a_din = 8'(i);
      step();
      checks++;
      if ({a_level, a_full, a_af, a_ae} !== {5'(i + 1), (i == 15), (i + 1 >= 12), (i + 1 <= 4)})
        $display("FAIL fill[%0d] level=%0d full=%b af=%b ae=%b", i, a_level, a_full, a_af, a_ae);
      else passed++;
    end
    a_din = 8'hFF;
    step();
    a_wr = 1'b0;
    checks++;
    if ({a_ovf, a_level, a_full} !== {1'b1, 5'd16, 1'b1})
      $display("FAIL overflow ovf=%b level=%0d full=%b exp 1/16/1", a_ovf, a_level, a_full);
    else passed++;
    step();
    checks++;
    if (a_ovf !== 1'b0) $display("FAIL overflow_clear ovf=%b exp 0", a_ovf); else passed++;
  endtask

  task automatic test_drain();
    a_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if ({a_dout, a_level} !== {8'(i), 5'(15 - i)})
        $display("FAIL drain[%0d] dout=%h level=%0d", i, a_dout, a_level);
      else passed++;
    end
    checks++;
    if (a_empty !== 1'b1) $display("FAIL drain_empty empty=%b exp 1", a_empty); else passed++;
    step();
    a_rd = 1'b0;
    checks++;
    if ({a_unf, a_dout, a_level} !== {1'b1, 8'h0F, 5'd0})
      $display("FAIL underflow unf=%b dout=%h level=%0d exp 1/0f/0", a_unf, a_dout, a_level);
    else passed++;
    step();
    checks++;
    if (a_unf !== 1'b0) $display("FAIL underflow_clear unf=%b exp 0", a_unf); else passed++;
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) begin
      a_wr = 1'b1;
      a_din = 8'(8'h30 + i);
      step();
    end
    a_rd = 1'b1;
    a_din = 8'hAA;
    step();
    a_wr = 1'b0;
    checks++;
    if ({a_level, a_ovf, a_dout} !== {5'd16, 1'b0, 8'h30})
      $display("FAIL full_rw level=%0d ovf=%b dout=%h exp 16/0/30", a_level, a_ovf, a_dout);
    else passed++;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (a_dout !== ((i == 16) ? 8'hAA : 8'(8'h30 + i)))
        $display("FAIL full_rw_read[%0d] dout=%h", i, a_dout);
      else passed++;
    end
    a_rd = 1'b0;
    step();
  endtask

  task automatic test_empty_rw();
    a_wr = 1'b1;
    a_rd = 1'b1;
    a_din = 8'h55;
    step();
    a_wr = 1'b0;
    checks++;
    if ({a_unf, a_level} !== {1'b1, 5'd1})
      $display("FAIL empty_rw unf=%b level=%0d exp 1/1", a_unf, a_level);
    else passed++;
    step();
    a_rd = 1'b0;
    checks++;
    if ({a_dout, a_level, a_unf} !== {8'h55, 5'd0, 1'b0})
      $display("FAIL empty_rw_read dout=%h level=%0d unf=%b exp 55/0/0", a_dout, a_level, a_unf);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] sbq[$];
    logic [7:0] exp_dout = 8'h00;
    logic       rok, wok;
    int         nwr = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      b_wr  = ($urandom_range(0, 3) != 0) ? (cyc < 40 || $urandom_range(0, 1) == 1) : 1'b0;
      b_rd  = (cyc < 40) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
      b_din = 8'($urandom_range(0, 255));
      rok = b_rd && (sbq.size() > 0);
      wok = b_wr && (sbq.size() < 5 || rok);
      if (rok) exp_dout = sbq.pop_front();
      if (wok) begin
        sbq.push_back(b_din);
        nwr++;
      end
      step();
      checks++;
      if ({b_dout, b_level, b_empty, b_full, b_af, b_ae, b_ovf, b_unf} !==
          {exp_dout, 3'(sbq.size()), sbq.size() == 0, sbq.size() == 5, sbq.size() >= 1,
           sbq.size() <= 4, b_wr && !wok, b_rd && !rok})
        $display("FAIL wrap[%0d] dout=%h/%h level=%0d/%0d ovf=%b unf=%b", cyc, b_dout, exp_dout,
                 b_level, sbq.size(), b_ovf, b_unf);
      else passed++;
      checks++;
      if (b_level > 3'd5) $display("FAIL wrap_range[%0d] level=%0d exp <=5", cyc, b_level);
      else passed++;
    end
    b_wr = 1'b0;
    b_rd = 1'b0;
    checks++;
    if (nwr < 15) $display("FAIL wrap_count writes=%0d exp >=15", nwr); else passed++;
  endtask

  task automatic test_fwft_fallthrough();
    c_wr = 1'b1;
    c_din = 8'h11;
    step();
    c_wr = 1'b0;
    checks++;
    if ({c_empty, c_level} !== {1'b1, 4'd1})
      $display("FAIL fwft_edgeN empty=%b level=%0d exp 1/1", c_empty, c_level);
    else passed++;
    step();
    checks++;
    if ({c_dout, c_empty} !== {8'h11, 1'b0})
      $display("FAIL fwft_edgeN1 dout=%h empty=%b exp 11/0", c_dout, c_empty);
    else passed++;
    c_rd = 1'b1;
    step();
    c_rd = 1'b0;
    checks++;
    if ({c_empty, c_level, c_unf} !== {1'b1, 4'd0, 1'b0})
      $display("FAIL fwft_pop empty=%b level=%0d unf=%b exp 1/0/0", c_empty, c_level, c_unf);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int widx = 0, ridx = 0, first = -1, last = -1;
    for (int cyc = 0; cyc < 40 && ridx < 16; cyc++) begin
      c_wr  = (widx < 16);
      c_din = 8'(8'h20 + widx);
      c_rd  = !c_empty;
      if (c_rd) begin
        checks++;
        if (c_dout !== 8'(8'h20 + ridx)) $display("FAIL b2b[%0d] dout=%h exp %h", ridx, c_dout, 8'(8'h20 + ridx));
        else passed++;
        if (first < 0) first = cyc;
        last = cyc;
        ridx++;
      end
      step();
      if (c_wr) widx++;
    end
    c_wr = 1'b0;
    c_rd = 1'b0;
    checks++;
    if (ridx != 16 || last - first != 15)
      $display("FAIL b2b_bubbles reads=%0d span=%0d exp 16/15", ridx, last - first);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    c_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_din = 8'(8'h70 + i);
      step();
    end
    c_wr = 1'b0;
    step();
    checks++;
    if ({c_empty, c_level, c_dout} !== {1'b0, 4'd3, 8'h70})
      $display("FAIL pre_reset empty=%b level=%0d dout=%h exp 0/3/70", c_empty, c_level, c_dout);
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({c_empty, c_level, c_dout} !== {1'b1, 4'd0, 8'h00})
      $display("FAIL mid_reset empty=%b level=%0d dout=%h exp 1/0/00", c_empty, c_level, c_dout);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_fwft_fallthrough();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
